// File: rtl/m6502_bus_responder.sv
// rtl/m6502_bus_responder.sv - memory-side bus target for the m6502 CPU with RAM, reset vector and read wait states
module m6502_bus_responder #(
  parameter int          MEM_BITS     = 12,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] RESET_VECTOR = 16'h0200,
  parameter logic [7:0]  OPEN_BUS     = 8'hFF,
  parameter int          WAIT_STATES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        rd_req,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Counter load value; WAIT is never entered when no wait states are configured.
  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [15:0] LP_VEC_LO = 16'hFFFC;
  localparam logic [15:0] LP_VEC_HI = 16'hFFFD;

  state_t      r_state;
  logic [15:0] r_addr_q;
  logic [3:0]  r_cnt;
  logic [7:0]  r_rd_data;
  logic        r_ready;

  // Local RAM; deliberately not cleared by reset.
  logic [7:0]  r_mem [0:(1 << MEM_BITS) - 1];

  logic        w_wr_hit;
  logic        w_rd_in_win;
  logic [7:0]  w_rd_src;

  // Posted writes land only inside the RAM window and never on the vector bytes.
  assign w_wr_hit = wr_en
                    && (addr[15:MEM_BITS] == BASE_ADDR[15:MEM_BITS])
                    && (addr != LP_VEC_LO)
                    && (addr != LP_VEC_HI);

  assign w_rd_in_win = (r_addr_q[15:MEM_BITS] == BASE_ADDR[15:MEM_BITS]);

  // Read source decode on the latched address, vector bytes taking priority over RAM.
  always_comb begin
    w_rd_src = OPEN_BUS;
    if (r_addr_q == LP_VEC_LO) begin
      w_rd_src = RESET_VECTOR[7:0];
    end else if (r_addr_q == LP_VEC_HI) begin
      w_rd_src = RESET_VECTOR[15:8];
    end else if (w_rd_in_win) begin
      w_rd_src = r_mem[r_addr_q[MEM_BITS-1:0]];
    end
  end

  // RAM write port; accepted in every FSM state so writes never stall the CPU.
  always_ff @(posedge clk) begin
    if (w_wr_hit) begin
      r_mem[addr[MEM_BITS-1:0]] <= wr_data;
    end
  end

  // Read FSM: latch the request, burn the wait states, then register the data in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr_q  <= 16'h0000;
      r_cnt     <= 4'd0;
      r_rd_data <= 8'h00;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // DONE samples RAM after any write from earlier edges has committed.
          if (r_state == ST_DONE) begin
            r_rd_data <= w_rd_src;
          end
          if (rd_req) begin
            r_addr_q <= addr;
            if (WAIT_STATES > 0) begin
              r_cnt   <= LP_WAIT_LOAD;
              r_ready <= 1'b0;
              r_state <= ST_WAIT;
            end else begin
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Requests arriving here are illegal and dropped; no queuing.
          if (r_cnt == 4'd0) begin
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_data = r_rd_data;
  assign ready   = r_ready;

endmodule

// File: tb/tb_m6502_bus_responder.sv
// tb/tb_m6502_bus_responder.sv - directed self-checking bench for m6502_bus_responder
module tb_m6502_bus_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] addr;
  logic        rd_req;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        ready;

  logic [15:0] addr0;
  logic        rd_req0;
  logic        wr_en0;
  logic [7:0]  wr_data0;
  logic [7:0]  rd_data0;
  logic        ready0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  m6502_bus_responder #(
    .MEM_BITS(12), .BASE_ADDR(16'h0000), .RESET_VECTOR(16'h0200),
    .OPEN_BUS(8'hFF), .WAIT_STATES(2)
  ) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_req(rd_req), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready)
  );

  m6502_bus_responder #(
    .MEM_BITS(12), .BASE_ADDR(16'h0000), .RESET_VECTOR(16'h0200),
    .OPEN_BUS(8'hFF), .WAIT_STATES(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr0), .rd_req(rd_req0), .wr_en(wr_en0),
    .wr_data(wr_data0), .rd_data(rd_data0), .ready(ready0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Posted write on the wait-state instance; ready must stay high.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    edge_step();
    wr_en   = 1'b0;
    chk("wr_ready_high", {15'd0, ready}, 16'd1);
  endtask

  // Read on the WAIT_STATES=2 instance: ready low two cycles, data three edges after request.
  task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr   = a;
    rd_req = 1'b1;
    edge_step();
    rd_req = 1'b0;
    chk({tag, "_rdy_w1"}, {15'd0, ready}, 16'd0);
    edge_step();
    chk({tag, "_rdy_w2"}, {15'd0, ready}, 16'd0);
    edge_step();
    chk({tag, "_rdy_done"}, {15'd0, ready}, 16'd1);
    edge_step();
    chk({tag, "_data"}, {8'd0, rd_data}, {8'd0, exp});
    chk({tag, "_rdy_idle"}, {15'd0, ready}, 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    addr = 16'h0000; rd_req = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    addr0 = 16'h0000; rd_req0 = 1'b0; wr_en0 = 1'b0; wr_data0 = 8'h00;
    #2;
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_rd_data", {8'd0, rd_data}, 16'h0000);
    chk("rst_ready0", {15'd0, ready0}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    edge_step();

    // Reset vector bytes
    do_read("vec_lo", 16'hFFFC, 8'h00);
    do_read("vec_hi", 16'hFFFD, 8'h02);

    // Write then read back
    do_write(16'h0123, 8'hA5);
    do_read("rd_0123", 16'h0123, 8'hA5);

    // Unmapped read and aliasing write outside the window
    do_read("unmapped_8000", 16'h8000, 8'hFF);
    do_write(16'h9123, 8'h5A);
    do_read("no_alias_0123", 16'h0123, 8'hA5);

    // Window edges: last RAM byte and first byte past it
    do_write(16'h0FFF, 8'hC3);
    do_read("win_top", 16'h0FFF, 8'hC3);
    do_read("win_past", 16'h1000, 8'hFF);

    // Writes to the vector bytes are dropped
    do_write(16'hFFFD, 8'h99);
    do_read("vec_hi_kept", 16'hFFFD, 8'h02);

    // Same-edge read and write to one address returns the new byte
    addr = 16'h0040; wr_data = 8'h3C; wr_en = 1'b1; rd_req = 1'b1;
    edge_step();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("rw_same_rdy", {15'd0, ready}, 16'd0);
    edge_step(); edge_step(); edge_step();
    chk("rw_same_data", {8'd0, rd_data}, 16'h003C);

    // Write during WAIT to the address under read; stray rd_req in WAIT is ignored
    addr = 16'h0040; rd_req = 1'b1;
    edge_step();
    rd_req = 1'b0;
    addr = 16'h0040; wr_data = 8'h77; wr_en = 1'b1;
    edge_step();
    wr_en = 1'b0;
    chk("wait_wr_rdy", {15'd0, ready}, 16'd0);
    addr = 16'h8000; rd_req = 1'b1;
    edge_step();
    rd_req = 1'b0;
    chk("wait_done_rdy", {15'd0, ready}, 16'd1);
    edge_step();
    chk("wait_wr_data", {8'd0, rd_data}, 16'h0077);
    edge_step();
    chk("stray_req_ignored", {15'd0, ready}, 16'd1);
    chk("stray_req_hold", {8'd0, rd_data}, 16'h0077);

    // Zero wait states: back-to-back reads
    addr0 = 16'h0010; wr_data0 = 8'h11; wr_en0 = 1'b1;
    edge_step();
    addr0 = 16'h0011; wr_data0 = 8'h22;
    edge_step();
    wr_en0 = 1'b0;
    addr0 = 16'h0010; rd_req0 = 1'b1;
    edge_step();
    chk("ws0_rdy_a", {15'd0, ready0}, 16'd1);
    addr0 = 16'h0011;
    edge_step();
    rd_req0 = 1'b0;
    chk("ws0_data_a", {8'd0, rd_data0}, 16'h0011);
    chk("ws0_rdy_b", {15'd0, ready0}, 16'd1);
    edge_step();
    chk("ws0_data_b", {8'd0, rd_data0}, 16'h0022);
    edge_step();
    chk("ws0_hold", {8'd0, rd_data0}, 16'h0022);

    // Asynchronous reset in the middle of a read
    do_read("pre_rst", 16'h0123, 8'hA5);
    addr = 16'h8000; rd_req = 1'b1;
    edge_step();
    rd_req = 1'b0;
    chk("mid_rst_wait", {15'd0, ready}, 16'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", {15'd0, ready}, 16'd1);
    chk("mid_rst_data", {8'd0, rd_data}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    edge_step();
    do_read("post_rst_ram", 16'h0123, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
